// File: rtl/heap_pkg.sv
// Shared types and default geometry for the heap memory and the engines that read it.
package heap_pkg;

  localparam int DEFAULT_DATA_WIDTH = 12;
  localparam int DEFAULT_ADDR_WIDTH = 12;
  localparam int DEFAULT_AREA       = 4;
  localparam int DEFAULT_ARRAYS     = 16;

  typedef enum logic [1:0] {
    FIRST_EQ = 2'd0,
    LAST_EQ  = 2'd1,
    COUNT_EQ = 2'd2,
    COUNT_LT = 2'd3
  } search_mode_t;

endpackage

// File: rtl/heap_array_search.sv
// Streams one fixed-area heap array through the memory read port, one element per cycle,
// and returns a first/last match index (1-based, 0 = none) or an equal/less-than count.
//
// state | meaning
// IDLE  | waiting for start, ready high
// SCAN  | issuing one read per cycle, evaluating the previous element's data
// DRAIN | no more reads, evaluating the last outstanding element
// DONE  | one-cycle done pulse with result, ready high, back-to-back start accepted
module heap_array_search
  import heap_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int AREA        = DEFAULT_AREA,
  parameter int ARRAYS      = DEFAULT_ARRAYS,
  localparam int ARRAY_WIDTH = $clog2(ARRAYS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ARRAY_WIDTH-1:0] array,
  input  logic [DATA_WIDTH-1:0]  size,
  input  logic [DATA_WIDTH-1:0]  key,
  input  logic [1:0]             mode,
  output logic                   ready,
  output logic                   mem_read,
  output logic [ADDR_WIDTH-1:0]  mem_address,
  input  logic [DATA_WIDTH-1:0]  mem_data,
  output logic                   done,
  output logic [DATA_WIDTH-1:0]  result
);

  localparam int IDX_W  = $clog2(AREA + 1);
  localparam int FULL_W = ADDR_WIDTH + ARRAY_WIDTH;
  localparam logic [DATA_WIDTH-1:0] AREA_D = DATA_WIDTH'(AREA);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [ARRAY_WIDTH-1:0] array_q, array_d;
  logic [DATA_WIDTH-1:0]  key_q, key_d;
  search_mode_t           mode_q, mode_d;
  logic [IDX_W-1:0]       rem_q, rem_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       eidx_q, eidx_d;
  logic                   dvalid_q, dvalid_d;
  logic [DATA_WIDTH-1:0]  acc_q, acc_d;
  logic                   ready_q, ready_d;
  logic                   done_q, done_d;
  logic                   mem_read_q, mem_read_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  result_q, result_d;

  logic                   is_eq, is_lt, hit;
  logic [DATA_WIDTH-1:0]  acc_eval, j_plus1;
  logic [IDX_W-1:0]       n_clamped;

  // Product and offset are formed wide and then truncated, so large array numbers wrap silently.
  function automatic logic [ADDR_WIDTH-1:0] elem_addr(input logic [ARRAY_WIDTH-1:0] arr,
                                                      input logic [IDX_W-1:0] idx);
    logic [FULL_W-1:0] full;
    full = FULL_W'(arr) * FULL_W'(AREA) + FULL_W'(idx);
    return full[ADDR_WIDTH-1:0];
  endfunction

  always_comb begin
    state_d    = state_q;
    array_d    = array_q;
    key_d      = key_q;
    mode_d     = mode_q;
    rem_d      = rem_q;
    idx_d      = idx_q;
    eidx_d     = eidx_q;
    dvalid_d   = 1'b0;
    ready_d    = ready_q;
    done_d     = 1'b0;
    mem_read_d = 1'b0;
    addr_d     = addr_q;
    result_d   = result_q;

    is_eq     = (mem_data == key_q);
    is_lt     = (mem_data < key_q);
    j_plus1   = DATA_WIDTH'(eidx_q) + DATA_WIDTH'(1);
    hit       = 1'b0;
    acc_eval  = acc_q;
    n_clamped = (size > AREA_D) ? IDX_W'(AREA) : IDX_W'(size);

    if (dvalid_q) begin
      case (mode_q)
        FIRST_EQ: begin
          if (is_eq && (acc_q == '0)) begin
            acc_eval = j_plus1;
            hit      = 1'b1;
          end
        end
        LAST_EQ:  if (is_eq) acc_eval = j_plus1;
        COUNT_EQ: acc_eval = acc_q + DATA_WIDTH'(is_eq);
        COUNT_LT: acc_eval = acc_q + DATA_WIDTH'(is_lt);
        default:  acc_eval = acc_q;
      endcase
    end
    acc_d = acc_eval;

    case (state_q)
      IDLE: ;
      SCAN: begin
        if (hit) begin
          // Early exit: the read issued this cycle is simply never evaluated.
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = acc_eval;
        end else begin
          dvalid_d = 1'b1;
          eidx_d   = idx_q;
          if (rem_q == '0) begin
            state_d = DRAIN;
          end else begin
            rem_d      = rem_q - IDX_W'(1);
            idx_d      = idx_q + IDX_W'(1);
            mem_read_d = 1'b1;
            addr_d     = elem_addr(array_q, idx_q + IDX_W'(1));
          end
        end
      end
      DRAIN: begin
        state_d  = DONE;
        done_d   = 1'b1;
        result_d = acc_eval;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (ready_q && start) begin
      array_d  = array;
      key_d    = key;
      mode_d   = search_mode_t'(mode);
      acc_d    = '0;
      idx_d    = '0;
      eidx_d   = '0;
      dvalid_d = 1'b0;
      if (n_clamped == '0) begin
        state_d    = DONE;
        done_d     = 1'b1;
        result_d   = '0;
        mem_read_d = 1'b0;
        rem_d      = '0;
      end else begin
        state_d    = SCAN;
        done_d     = 1'b0;
        mem_read_d = 1'b1;
        addr_d     = elem_addr(array, '0);
        rem_d      = n_clamped - IDX_W'(1);
      end
    end

    ready_d = (state_d == IDLE) || (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      array_q    <= '0;
      key_q      <= '0;
      mode_q     <= FIRST_EQ;
      rem_q      <= '0;
      idx_q      <= '0;
      eidx_q     <= '0;
      dvalid_q   <= 1'b0;
      acc_q      <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      mem_read_q <= 1'b0;
      addr_q     <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      array_q    <= array_d;
      key_q      <= key_d;
      mode_q     <= mode_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      eidx_q     <= eidx_d;
      dvalid_q   <= dvalid_d;
      acc_q      <= acc_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      mem_read_q <= mem_read_d;
      addr_q     <= addr_d;
      result_q   <= result_d;
    end
  end

  assign ready       = ready_q;
  assign done        = done_q;
  assign mem_read    = mem_read_q;
  assign mem_address = addr_q;
  assign result      = result_q;

endmodule

// File: tb/tb_heap_array_search.sv
// Self-checking bench for heap_array_search: directed vector table, corner sequences,
// and randomized searches against an array-walking reference model.
module tb_heap_array_search;
  import heap_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  array = '0;
  logic [11:0] size  = '0;
  logic [11:0] key   = '0;
  logic [1:0]  mode  = '0;
  logic        ready, mem_read, done;
  logic [11:0] mem_address, result;
  logic [11:0] mem_data;
  logic [11:0] mem [0:4095];

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  arr;
    logic [11:0] sz;
    logic [11:0] k;
    logic [1:0]  md;
    logic [11:0] exp_res;
    int          exp_dcyc;
    int          exp_reads;
  } vec_t;

  vec_t vecs [10];

  always #5 clock = ~clock;

  always @(posedge clock) if (mem_read) mem_data <= mem[mem_address];

  heap_array_search dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .array      (array),
    .size       (size),
    .key        (key),
    .mode       (mode),
    .ready      (ready),
    .mem_read   (mem_read),
    .mem_address(mem_address),
    .mem_data   (mem_data),
    .done       (done),
    .result     (result)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: walk the array in memory order and apply the mode's rule directly.
  function automatic void model(input logic [3:0] arr, input logic [11:0] sz, input logic [11:0] k,
                                input logic [1:0] md, output logic [11:0] res,
                                output int dcyc, output int reads);
    int n;
    int base;
    n     = (sz > 12'd4) ? 4 : int'(sz);
    base  = int'(arr) * 4;
    res   = '0;
    dcyc  = (n == 0) ? 0 : n + 1;
    reads = n;
    for (int j = 0; j < n; j++) begin
      logic [11:0] d;
      d = mem[(base + j) % 4096];
      if (md == 2'd0) begin
        if (d == k) begin
          res   = 12'(j + 1);
          dcyc  = j + 2;
          reads = (j + 2 < n) ? j + 2 : n;
          break;
        end
      end else if (md == 2'd1) begin
        if (d == k) res = 12'(j + 1);
      end else if (md == 2'd2) begin
        if (d == k) res = res + 12'd1;
      end else begin
        if (d < k) res = res + 12'd1;
      end
    end
  endfunction

  task automatic issue(input logic [3:0] arr, input logic [11:0] sz, input logic [11:0] k,
                       input logic [1:0] md);
    array = arr;
    size  = sz;
    key   = k;
    mode  = md;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Called at cycle 0 (#1 after the accepting edge); returns in the done cycle.
  task automatic monitor(input logic [3:0] arr, output int dcyc, output int reads,
                         output int bad_addr, output logic [11:0] res, output int rdy_err);
    dcyc     = -1;
    reads    = 0;
    bad_addr = 0;
    rdy_err  = 0;
    res      = '0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin
        @(posedge clock);
        #1;
      end
      if (mem_read) begin
        if (c != reads || mem_address != 12'((int'(arr) * 4 + c) % 4096)) bad_addr++;
        reads++;
      end
      if (done) begin
        dcyc = c;
        res  = result;
        if (!ready) rdy_err++;
        break;
      end else if (ready) begin
        rdy_err++;
      end
    end
  endtask

  task automatic run(input string tag, input logic [3:0] arr, input logic [11:0] sz,
                     input logic [11:0] k, input logic [1:0] md, input logic [11:0] exp_res,
                     input int exp_dcyc, input int exp_reads);
    int dcyc, reads, bad, rdy;
    logic [11:0] res;
    issue(arr, sz, k, md);
    monitor(arr, dcyc, reads, bad, res, rdy);
    check({tag, " done_cycle"}, dcyc, exp_dcyc);
    check({tag, " result"}, res, exp_res);
    check({tag, " reads"}, reads, exp_reads);
    check({tag, " bad_addr"}, bad, 0);
    check({tag, " ready"}, rdy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [11:0] mres;
    int mdcyc, mreads;
    int dcyc, reads, bad, rdy;
    logic [11:0] res;

    for (int a = 0; a < 4096; a++) mem[a] = (a < 64) ? 12'($urandom_range(0, 7)) : 12'd0;
    mem[0] = 12'd10; mem[1] = 12'd20; mem[2] = 12'd30; mem[3] = 12'd99;
    mem[4] = 12'd5;  mem[5] = 12'd7;  mem[6] = 12'd5;  mem[7] = 12'd5;
    mem[8] = 12'd1;  mem[9] = 12'd2;  mem[10] = 12'd3; mem[11] = 12'd4;

    vecs[0] = '{4'd0, 12'd3, 12'd20,   FIRST_EQ, 12'd2, 3, 3};
    vecs[1] = '{4'd1, 12'd4, 12'd5,    LAST_EQ,  12'd4, 5, 4};
    vecs[2] = '{4'd1, 12'd4, 12'd5,    COUNT_EQ, 12'd3, 5, 4};
    vecs[3] = '{4'd1, 12'd4, 12'd6,    COUNT_LT, 12'd3, 5, 4};
    vecs[4] = '{4'd1, 12'd4, 12'd5,    FIRST_EQ, 12'd1, 2, 2};
    vecs[5] = '{4'd1, 12'd0, 12'd5,    COUNT_EQ, 12'd0, 0, 0};
    vecs[6] = '{4'd3, 12'd9, 12'd4095, COUNT_LT, 12'd4, 5, 4};
    vecs[7] = '{4'd2, 12'd4, 12'd50,   FIRST_EQ, 12'd0, 5, 4};
    vecs[8] = '{4'd2, 12'd4, 12'd3,    COUNT_LT, 12'd2, 5, 4};
    vecs[9] = '{4'd1, 12'd4, 12'd7,    LAST_EQ,  12'd2, 5, 4};

    repeat (3) @(posedge clock);
    #1;
    check("rst ready", ready, 1);
    check("rst done", done, 0);
    check("rst mem_read", mem_read, 0);
    check("rst mem_address", mem_address, 0);
    check("rst result", result, 0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Each entry is issued from the previous entry's done cycle (back-to-back acceptance).
    for (int v = 0; v < 10; v++)
      run($sformatf("vec%0d", v), vecs[v].arr, vecs[v].sz, vecs[v].k, vecs[v].md,
          vecs[v].exp_res, vecs[v].exp_dcyc, vecs[v].exp_reads);

    // Reset in cycle 1 of a 4-element scan.
    @(posedge clock);
    #1;
    issue(4'd1, 12'd4, 12'd5, COUNT_EQ);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("midrst ready", ready, 1);
    check("midrst done", done, 0);
    check("midrst mem_read", midrst_dummy(mem_read), 0);
    check("midrst result", result, 0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("postrst mem_read", mem_read, 0);
    check("postrst done", done, 0);
    run("postrst", 4'd1, 12'd4, 12'd5, LAST_EQ, 12'd4, 5, 4);

    // start pulsed and inputs changed mid-scan must not disturb the latched request.
    @(posedge clock);
    #1;
    issue(4'd1, 12'd4, 12'd5, COUNT_EQ);
    start = 1'b1;
    key   = 12'd7;
    array = 4'd2;
    mode  = FIRST_EQ;
    size  = 12'd0;
    fork
      monitor(4'd1, dcyc, reads, bad, res, rdy);
      begin
        repeat (2) @(posedge clock);
        #2;
        start = 1'b0;
      end
    join
    check("ignore done_cycle", dcyc, 5);
    check("ignore result", res, 3);
    check("ignore reads", reads, 4);
    check("ignore bad_addr", bad, 0);

    for (int r = 0; r < 60; r++) begin
      logic [3:0]  ra;
      logic [11:0] rs, rk;
      logic [1:0]  rm;
      ra = 4'($urandom_range(0, 15));
      rs = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(5, 4095)) : 12'($urandom_range(0, 5));
      rk = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 8));
      rm = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock);
        #1;
      end
      model(ra, rs, rk, rm, mres, mdcyc, mreads);
      run($sformatf("rnd%0d", r), ra, rs, rk, rm, mres, mdcyc, mreads);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  function automatic logic midrst_dummy(input logic v);
    return v;
  endfunction

endmodule
